// File: rtl/cmul_sched.sv
// rtl/cmul_sched.sv - complex multiply sequencer sharing one real Q-format multiplier
// Optional feature: define CMUL_SAT_EN to saturate o_re/o_im instead of wrapping.

module cmul_sched #(
   parameter int N       = 16,
   parameter int Q       = 8,
   parameter int MUL_LAT = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_ar,
   input  logic [N-1:0] i_ai,
   input  logic [N-1:0] i_br,
   input  logic [N-1:0] i_bi,
   output logic [N-1:0] o_mul_a,
   output logic [N-1:0] o_mul_b,
   output logic         o_mul_issue,
   input  logic [N-1:0] i_mul_p,
   output logic         o_valid,
   input  logic         i_out_ready,
   output logic [N-1:0] o_re,
   output logic [N-1:0] o_im
);

   if (Q < 0 || Q >= N || MUL_LAT < 1 || MUL_LAT > 7) begin : g_bad_cfg
      $error("cmul_sched: unsupported Q or MUL_LAT");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t               state_q;
   logic [1:0]           k_q;
   logic [2:0]           ret_q;
   logic [MUL_LAT-1:0]   lat_q;
   logic [N-1:0]         ar_q, ai_q, br_q, bi_q;
   logic [N-1:0]         p0_q, p1_q, p2_q;
   logic                 ready_q, valid_q, issue_q;
   logic [N-1:0]         mul_a_q, mul_b_q, re_q, im_q;
   logic [N-1:0]         re_d, im_d;
   logic                 capture;

   // lat_q is the issue strobe delayed by MUL_LAT; its tail marks a returning product
   assign capture = lat_q[MUL_LAT-1];

`ifdef CMUL_SAT_EN
   logic [N:0] re_w, im_w;

   always_comb begin
      re_w = {p0_q[N-1], p0_q} - {p1_q[N-1], p1_q};
      im_w = {p2_q[N-1], p2_q} + {i_mul_p[N-1], i_mul_p};
      re_d = re_w[N-1:0];
      im_d = im_w[N-1:0];
      if (re_w[N] != re_w[N-1])
         re_d = re_w[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      if (im_w[N] != im_w[N-1])
         im_d = im_w[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
   end
`else
   always_comb begin
      re_d = p0_q - p1_q;
      im_d = p2_q + i_mul_p;
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         ret_q   <= '0;
         lat_q   <= '0;
         ar_q    <= '0;
         ai_q    <= '0;
         br_q    <= '0;
         bi_q    <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         issue_q <= 1'b0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         re_q    <= '0;
         im_q    <= '0;
      end else begin
         lat_q[0] <= issue_q;
         for (int i = 1; i < MUL_LAT; i++) lat_q[i] <= lat_q[i-1];

         if (capture) begin
            case (ret_q)
               3'd0:    p0_q <= i_mul_p;
               3'd1:    p1_q <= i_mul_p;
               3'd2:    p2_q <= i_mul_p;
               default: ;
            endcase
            ret_q <= ret_q + 3'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  ar_q    <= i_ar;
                  ai_q    <= i_ai;
                  br_q    <= i_br;
                  bi_q    <= i_bi;
                  k_q     <= 2'd0;
                  ret_q   <= 3'd0;
                  ready_q <= 1'b0;
                  issue_q <= 1'b1;
                  mul_a_q <= i_ar;
                  mul_b_q <= i_br;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               k_q <= k_q + 2'd1;
               case (k_q)
                  2'd0: begin mul_a_q <= ai_q; mul_b_q <= bi_q; end
                  2'd1: begin mul_a_q <= ar_q; mul_b_q <= bi_q; end
                  2'd2: begin mul_a_q <= ai_q; mul_b_q <= br_q; end
                  default: begin
                     mul_a_q <= '0;
                     mul_b_q <= '0;
                     issue_q <= 1'b0;
                     state_q <= S_DRAIN;
                  end
               endcase
            end
            S_DRAIN: begin
               // the fourth product is summed straight off the bus as it lands
               if (capture && ret_q == 3'd3) begin
                  re_q    <= re_d;
                  im_q    <= im_d;
                  valid_q <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               if (i_out_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign o_ready     = ready_q;
   assign o_valid     = valid_q;
   assign o_mul_issue = issue_q;
   assign o_mul_a     = mul_a_q;
   assign o_mul_b     = mul_b_q;
   assign o_re        = re_q;
   assign o_im        = im_q;

endmodule

// File: tb/tb_cmul_sched.sv
// tb/tb_cmul_sched.sv - scoreboard bench for cmul_sched at MUL_LAT 3, 1 and 7 in parallel
`timescale 1ns/1ps

module tb_cmul_sched;
   localparam int NDUT = 3;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_out_ready = 1'b1;
   logic [15:0] ar = '0, ai = '0, br = '0, bi = '0;

   logic        rdy [NDUT];
   logic        vld [NDUT];
   logic        iss [NDUT];
   logic [15:0] ma [NDUT];
   logic [15:0] mb [NDUT];
   logic [15:0] mp [NDUT];
   logic [15:0] re [NDUT];
   logic [15:0] im [NDUT];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [31:0] sb [NDUT][$];

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] pr;
      pr = $signed(a) * $signed(b);
      pr = pr >>> 8;
      return pr[15:0];
   endfunction

   function automatic logic [31:0] cmul_model(input logic [15:0] a0, a1, b0, b1);
      logic signed [15:0] s0, s1, s2, s3;
      int r, i;
      s0 = qmul(a0, b0);
      s1 = qmul(a1, b1);
      s2 = qmul(a0, b1);
      s3 = qmul(a1, b0);
      r = int'(s0) - int'(s1);
      i = int'(s2) + int'(s3);
`ifdef CMUL_SAT_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (i > 32767) i = 32767;
      if (i < -32768) i = -32768;
`endif
      return {r[15:0], i[15:0]};
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int L = (g == 0) ? 3 : ((g == 1) ? 1 : 7);
      logic [15:0] pipe [L];
      int          acc_cyc = 0;
      bit          seen = 0, pv = 0, pr = 0;
      logic [15:0] pre = '0, pim = '0;

      cmul_sched #(.N(16), .Q(8), .MUL_LAT(L)) u_dut (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_valid     (i_valid),
         .o_ready     (rdy[g]),
         .i_ar        (ar),
         .i_ai        (ai),
         .i_br        (br),
         .i_bi        (bi),
         .o_mul_a     (ma[g]),
         .o_mul_b     (mb[g]),
         .o_mul_issue (iss[g]),
         .i_mul_p     (mp[g]),
         .o_valid     (vld[g]),
         .i_out_ready (i_out_ready),
         .o_re        (re[g]),
         .o_im        (im[g])
      );

      always @(posedge i_clk) begin
         pipe[0] <= qmul(ma[g], mb[g]);
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign mp[g] = pipe[L-1];

      always @(negedge i_clk) begin
         if (!i_rst) begin
            if (i_valid && rdy[g]) acc_cyc = cyc;
            if (pv && !pr)
               check($sformatf("hold_l%0d", L), {31'b0, vld[g], re[g], im[g]}, {31'b0, 1'b1, pre, pim});
            if (vld[g] && !seen) begin
               check($sformatf("latency_l%0d", L), 64'(cyc - acc_cyc), 64'(5 + L));
               seen = 1;
            end
            if (vld[g] && i_out_ready) begin
               if (sb[g].size() == 0)
                  check($sformatf("unexpected_valid_l%0d", L), 64'(1), 64'(0));
               else
                  check($sformatf("result_l%0d", L), {32'b0, re[g], im[g]}, {32'b0, sb[g].pop_front()});
               seen = 0;
            end
            pv  = vld[g];
            pr  = i_out_ready;
            pre = re[g];
            pim = im[g];
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!(rdy[0] && rdy[1] && rdy[2]) && n < 200) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (n >= 200) check("idle_timeout", 64'(0), 64'(1));
   endtask

   task automatic do_op(input logic [15:0] a0, a1, b0, b1, input logic [31:0] exp, input bit chk_issue);
      logic [15:0] pa [4];
      logic [15:0] pb [4];
      wait_idle();
      ar = a0; ai = a1; br = b0; bi = b1;
      i_valid = 1'b1;
      for (int g = 0; g < NDUT; g++) sb[g].push_back(exp);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      if (chk_issue) begin
         pa[0] = a0; pb[0] = b0;
         pa[1] = a1; pb[1] = b1;
         pa[2] = a0; pb[2] = b1;
         pa[3] = a1; pb[3] = b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            for (int g = 0; g < NDUT; g++)
               check($sformatf("issue_k%0d_d%0d", k, g), {31'b0, iss[g], ma[g], mb[g]}, {31'b0, 1'b1, pa[k], pb[k]});
         end
         @(negedge i_clk);
         for (int g = 0; g < NDUT; g++)
            check($sformatf("issue_end_d%0d", g), {31'b0, iss[g], ma[g], mb[g]}, 64'(0));
      end
   endtask

   initial begin
      logic [15:0] r0, r1, r2, r3;
      int n;
      bit any_v;

      repeat (3) @(posedge i_clk);
      #1;
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("rst_ctl_d%0d", g), {61'b0, rdy[g], vld[g], iss[g]}, 64'b100);
         check($sformatf("rst_dat_d%0d", g), {ma[g], mb[g], re[g], im[g]}, 64'(0));
      end
      i_rst = 1'b0;

      do_op(16'h0100, 16'h0200, 16'h0080, 16'h0040, {16'h0000, 16'h0140}, 1'b1);
      do_op(16'hFF00, 16'h0000, 16'h0000, 16'h0100, {16'h0000, 16'hFF00}, 1'b0);
`ifdef CMUL_SAT_EN
      do_op(16'h7F00, 16'h8100, 16'h0100, 16'h0100, {16'h7FFF, 16'h0000}, 1'b0);
`else
      do_op(16'h7F00, 16'h8100, 16'h0100, 16'h0100, {16'hFE00, 16'h0000}, 1'b0);
`endif
      for (int t = 0; t < 6; t++) begin
         r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
         do_op(r0, r1, r2, r3, cmul_model(r0, r1, r2, r3), 1'b0);
      end

      // backpressure: results must sit still until released
      wait_idle();
      i_out_ready = 1'b0;
      do_op(16'h0100, 16'h0200, 16'h0080, 16'h0040, {16'h0000, 16'h0140}, 1'b0);
      n = 0;
      while (!(vld[0] && vld[1] && vld[2]) && n < 50) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (n >= 50) check("bp_valid_timeout", 64'(0), 64'(1));
      repeat (10) begin
         @(negedge i_clk);
         for (int g = 0; g < NDUT; g++) check($sformatf("bp_ready_d%0d", g), 64'(rdy[g]), 64'(0));
      end
      @(posedge i_clk); #1;
      i_out_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      for (int g = 0; g < NDUT; g++)
         check($sformatf("bp_release_d%0d", g), {62'b0, rdy[g], vld[g]}, 64'b10);

      // reset in the middle of ISSUE
      wait_idle();
      ar = 16'h0100; ai = 16'h0200; br = 16'h0080; bi = 16'h0040;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      #1;
      for (int g = 0; g < NDUT; g++)
         check($sformatf("mid_rst_d%0d", g), {62'b0, iss[g], rdy[g]}, 64'b01);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      any_v = 1'b0;
      repeat (20) begin
         @(negedge i_clk);
         for (int g = 0; g < NDUT; g++) any_v |= vld[g];
      end
      check("no_valid_after_rst", 64'(any_v), 64'(0));

      @(posedge i_clk); #1;
      do_op(16'h0100, 16'h0200, 16'h0080, 16'h0040, {16'h0000, 16'h0140}, 1'b1);
      wait_idle();
      repeat (3) @(posedge i_clk);
      check("sb_left", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
